// File: rtl/iob_rom_stream_pkg.sv
// Shared FSM encodings, FIFO sizing and the read-credit helper for iob_rom_stream.
package iob_rom_stream_pkg;

  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // True when a new read issued now can still land in the FIFO without overflow.
  function automatic logic credit_ok(input logic [FIFO_CNT_W-1:0] occ,
                                     input logic                  pend,
                                     input logic                  pop);
    logic [FIFO_CNT_W:0] total;
    total = (FIFO_CNT_W+1)'(occ) + (FIFO_CNT_W+1)'(pend) - (FIFO_CNT_W+1)'(pop);
    return total < (FIFO_CNT_W+1)'(FIFO_DEPTH);
  endfunction

endpackage

// File: rtl/iob_rom_stream_skid.sv
// Two-entry output FIFO with valid/ready on both sides; head entry drives the output.
module iob_rom_stream_skid
  import iob_rom_stream_pkg::*;
#(
  parameter int unsigned W = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_s_valid,
  output logic                  o_s_ready,
  input  logic [W-1:0]          i_s_data,
  output logic                  o_m_valid,
  input  logic                  i_m_ready,
  output logic [W-1:0]          o_m_data,
  output logic [FIFO_CNT_W-1:0] o_count
);

  localparam logic [FIFO_CNT_W-1:0] CNT_FULL = FIFO_CNT_W'(FIFO_DEPTH);
  localparam logic [FIFO_CNT_W-1:0] CNT_ONE  = FIFO_CNT_W'(1);

  logic [W-1:0]          r_head;
  logic [W-1:0]          r_tail;
  logic [FIFO_CNT_W-1:0] r_count;
  logic                  w_push;
  logic                  w_pop;

  assign o_m_valid = (r_count != '0);
  assign o_m_data  = r_head;
  assign o_count   = r_count;
  // A full FIFO can still take a word in the same cycle its head leaves.
  assign o_s_ready = (r_count != CNT_FULL) || i_m_ready;
  assign w_push    = i_s_valid && o_s_ready;
  assign w_pop     = o_m_valid && i_m_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == '0) r_head <= i_s_data;
          else               r_tail <= i_s_data;
          r_count <= r_count + CNT_ONE;
        end
        2'b01: begin
          if (r_count == CNT_FULL) r_head <= r_tail;
          r_count <= r_count - CNT_ONE;
        end
        2'b11: begin
          if (r_count == CNT_ONE) begin
            r_head <= i_s_data;
          end else begin
            r_head <= r_tail;
            r_tail <= i_s_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/iob_rom_stream.sv
// Streams a burst of ROM words (one-cycle read latency) to a valid/ready sink.
// Defining IOB_ROM_STREAM_LOOP_EN adds a stop input and repeats the burst until stopped.
module iob_rom_stream
  import iob_rom_stream_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
`ifdef IOB_ROM_STREAM_LOOP_EN
  input  logic              stop,
`endif
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic              r_en,
  output logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] r_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last
);

  localparam int unsigned LEN_W  = ADDR_W + 1;
  localparam int unsigned WORD_W = DATA_W + 1;

  state_t                r_state;
  logic [LEN_W-1:0]      r_len;
  logic [LEN_W-1:0]      r_issued;
  logic [ADDR_W-1:0]     r_addr;
  logic [ADDR_W-1:0]     r_start_addr;
  logic                  r_rd_pend;
  logic                  r_pend_last;
  logic                  r_busy;
  logic                  r_done;

  logic [FIFO_CNT_W-1:0] w_count;
  logic                  w_s_ready;
  logic [WORD_W-1:0]     w_m_word;
  logic                  w_hs;
  logic                  w_issue;
  logic                  w_pass_end;
  logic                  w_final_out;
  logic                  w_stop_now;

`ifdef IOB_ROM_STREAM_LOOP_EN
  logic                  r_stop;
  assign w_stop_now = r_stop || stop;
`else
  assign w_stop_now = 1'b1;
`endif

  assign w_hs = m_valid && m_ready;

  // Read issue is decided in-cycle so the current handshake frees a slot immediately.
  assign w_issue = (r_state == ST_RUN) && !rst && (r_issued < r_len) && w_s_ready &&
                   credit_ok(w_count, r_rd_pend, w_hs);
  assign w_pass_end  = w_issue && ((r_issued + LEN_W'(1)) == r_len);
  assign w_final_out = w_hs && (w_count == FIFO_CNT_W'(1)) && !r_rd_pend;

  assign r_en = w_issue;
  assign addr = r_addr;
  assign busy = r_busy;
  assign done = r_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_len        <= '0;
      r_issued     <= '0;
      r_addr       <= '0;
      r_start_addr <= '0;
      r_rd_pend    <= 1'b0;
      r_pend_last  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
`ifdef IOB_ROM_STREAM_LOOP_EN
      r_stop       <= 1'b0;
`endif
    end else begin
      r_done    <= 1'b0;
      r_rd_pend <= w_issue;
      if (w_issue) r_pend_last <= w_pass_end;
`ifdef IOB_ROM_STREAM_LOOP_EN
      if (r_state != ST_IDLE && stop) r_stop <= 1'b1;
`endif
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (len == '0) begin
              r_done <= 1'b1;
            end else begin
              r_state      <= ST_RUN;
              r_busy       <= 1'b1;
              r_len        <= len;
              r_issued     <= '0;
              r_addr       <= start_addr;
              r_start_addr <= start_addr;
`ifdef IOB_ROM_STREAM_LOOP_EN
              r_stop       <= 1'b0;
`endif
            end
          end
        end
        ST_RUN: begin
          if (w_issue) begin
            r_addr   <= r_addr + ADDR_W'(1);
            r_issued <= r_issued + LEN_W'(1);
            if (w_pass_end) begin
              if (w_stop_now) begin
                r_state <= ST_DRAIN;
              end else begin
                r_addr   <= r_start_addr;
                r_issued <= '0;
              end
            end
          end
        end
        ST_DRAIN: begin
          if (w_final_out) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  iob_rom_stream_skid #(
    .W (WORD_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .i_s_valid (r_rd_pend),
    .o_s_ready (w_s_ready),
    .i_s_data  ({r_pend_last, r_data}),
    .o_m_valid (m_valid),
    .i_m_ready (m_ready),
    .o_m_data  (w_m_word),
    .o_count   (w_count)
  );

  assign m_data = w_m_word[DATA_W-1:0];
  assign m_last = w_m_word[DATA_W];

endmodule

// File: tb/tb_iob_rom_stream.sv
// Directed bench for iob_rom_stream with a behavioural ROM (rom[i] = i + 32).
module tb_iob_rom_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] start_addr;
  logic [4:0] len;
  logic       busy, done, r_en, m_valid, m_ready, m_last;
  logic [3:0] addr;
  logic [7:0] r_data, m_data;
`ifdef IOB_ROM_STREAM_LOOP_EN
  logic       stop;
`endif

  logic [7:0] rom [16];
  logic [7:0] rom_q;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (r_en) rom_q <= rom[addr];
  assign r_data = rom_q;

  iob_rom_stream #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef IOB_ROM_STREAM_LOOP_EN
    .stop       (stop),
`endif
    .start      (start),
    .start_addr (start_addr),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .r_en       (r_en),
    .addr       (addr),
    .r_data     (r_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] sa;
    logic [4:0] len;
    logic [3:0] pat;    // m_ready per cycle, bit (cycle % 4)
    logic [7:0] first;
    logic [7:0] last;
    int         lat;    // expected first m_valid cycle, -1 = don't care
  } vec_t;

  task automatic run_burst(input vec_t v);
    int         nw = 0;
    int         nr = 0;
    int         cyc = 0;
    int         lat = -1;
    logic       stalled = 1'b0;
    logic [7:0] prev = '0;
    logic [7:0] got_first = '0;
    logic [7:0] got_last = '0;
    logic [7:0] exp_d;
    bit         fin = 1'b0;
    @(negedge clk);
    start = 1'b1; start_addr = v.sa; len = v.len; m_ready = v.pat[0];
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    while (!fin && cyc < 200) begin
      m_ready = v.pat[cyc % 4];
      if (v.len >= 5'd4 && cyc == 4) begin
        start = 1'b1; start_addr = 4'd9; len = 5'd2;
      end else begin
        start = 1'b0;
      end
      #1;
      if (m_valid && lat < 0) lat = cyc;
      if (stalled) chk("stall_hold", 32'({m_valid, m_data}), 32'({1'b1, prev}));
      if (r_en) begin
        chk("rd_addr", 32'(addr), 32'(4'(v.sa + 4'(nr))));
        nr++;
        chk("no_overrun", 32'((nr - nw) <= 3), 32'd1);
      end
      if (m_valid && m_ready) begin
        exp_d = 8'h20 + 8'(4'(v.sa + 4'(nw)));
        chk("data", 32'(m_data), 32'(exp_d));
        chk("last", 32'(m_last), 32'(nw == int'(v.len) - 1));
        if (nw == 0) got_first = m_data;
        got_last = m_data;
        nw++;
      end
      stalled = m_valid && !m_ready;
      prev    = m_data;
      if (done) begin
        chk("done_words", 32'(nw), 32'(v.len));
        chk("done_reads", 32'(nr), 32'(v.len));
        chk("done_busy", 32'(busy), 32'd0);
        fin = 1'b1;
      end else begin
        chk("busy", 32'(busy), 32'd1);
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    if (!fin) chk("timeout", 32'd0, 32'd1);
    chk("first_word", 32'(got_first), 32'(v.first));
    chk("last_word", 32'(got_last), 32'(v.last));
    if (v.lat >= 0) chk("first_latency", 32'(lat), 32'(v.lat));
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd0);
  endtask

  vec_t vecs [6];

  initial begin
    int nw;
    int cyc;
    bit bad;
    vec_t v;
    for (int i = 0; i < 16; i++) rom[i] = 8'(i + 32);
    vecs[0] = '{sa: 4'd0,  len: 5'd16, pat: 4'b1111, first: 8'h20, last: 8'h2F, lat: 2};
    vecs[1] = '{sa: 4'd14, len: 5'd4,  pat: 4'b1111, first: 8'h2E, last: 8'h21, lat: 2};
    vecs[2] = '{sa: 4'd0,  len: 5'd8,  pat: 4'b1001, first: 8'h20, last: 8'h27, lat: -1};
    vecs[3] = '{sa: 4'd15, len: 5'd3,  pat: 4'b1111, first: 8'h2F, last: 8'h21, lat: 2};
    vecs[4] = '{sa: 4'd3,  len: 5'd1,  pat: 4'b1111, first: 8'h23, last: 8'h23, lat: 2};
    vecs[5] = '{sa: 4'd7,  len: 5'd5,  pat: 4'b0101, first: 8'h27, last: 8'h2B, lat: -1};

    rst = 1'b1; start = 1'b0; start_addr = '0; len = '0; m_ready = 1'b0;
`ifdef IOB_ROM_STREAM_LOOP_EN
    stop = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", 32'({busy, done, r_en, m_valid, m_last}), 32'd0);
    chk("reset_data", 32'({addr, m_data}), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_burst(vecs[i]);

    // Zero-length burst: done next cycle, no reads, no words.
    @(negedge clk);
    start = 1'b1; start_addr = 4'd3; len = 5'd0; m_ready = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("len0_done", 32'({done, busy, r_en, m_valid}), 32'b1000);
    @(posedge clk);
    #1;
    chk("len0_after", 32'({done, busy, r_en, m_valid}), 32'b0000);

    // Reset three words into a 10-word burst.
    @(negedge clk);
    start = 1'b1; start_addr = 4'd0; len = 5'd10; m_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    nw = 0; cyc = 0;
    while (nw < 3 && cyc < 50) begin
      #1;
      if (m_valid && m_ready) nw++;
      @(negedge clk);
      cyc++;
    end
    chk("abort_reached", 32'(nw), 32'd3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_ctrl", 32'({busy, done, r_en, m_valid, m_last}), 32'd0);
    chk("abort_data", 32'({addr, m_data}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (m_valid || done || busy || r_en) bad = 1'b1;
      @(negedge clk);
    end
    chk("abort_quiet", 32'(bad), 32'd0);
    v = '{sa: 4'd5, len: 5'd2, pat: 4'b1111, first: 8'h25, last: 8'h26, lat: 2};
    run_burst(v);

`ifdef IOB_ROM_STREAM_LOOP_EN
    // Looping burst stopped during the second pass.
    @(negedge clk);
    start = 1'b1; start_addr = 4'd0; len = 5'd2; m_ready = 1'b1; stop = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    nw = 0; cyc = 0; bad = 1'b1;
    while (cyc < 100) begin
      if (cyc == 2) stop = 1'b1;
      #1;
      if (m_valid && m_ready) begin
        chk("loop_data", 32'(m_data), 32'(8'h20 + 8'(nw % 2)));
        chk("loop_last", 32'(m_last), 32'(nw % 2 == 1));
        nw++;
      end
      if (done) begin
        bad = 1'b0;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    chk("loop_done", 32'(bad), 32'd0);
    chk("loop_words", 32'(nw), 32'd4);
    stop = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
